traffic_phase_sequencer: RTL

//  Parametrised N-phase, M-signal-head traffic light sequencer. It is the successor to the fixed
//  6-phase junction controller. Phase durations and light patterns come from runtime tables, and

---
 rtl/traffic_pkg.sv | 15 +
 rtl/traffic_next_phase.sv | 24 ++
 rtl/traffic_phase_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes and sequencer state type for the traffic phase sequencer.
package traffic_pkg;

    localparam logic [2:0] LT_RED   = 3'b100;
    localparam logic [2:0] LT_AMBER = 3'b010;
    localparam logic [2:0] LT_GREEN = 3'b001;
    localparam logic [2:0] LT_OFF   = 3'b000;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        RUN     = 2'd1,
        FLASH   = 2'd2
    } tls_state_t;

endpackage

// File: rtl/traffic_next_phase.sv
// Rotating-priority search for the next phase to run, starting one past the current phase.
module traffic_next_phase #(
    parameter int NUM_PHASES = 6
) (
    input  logic [$clog2(NUM_PHASES)-1:0] cur,
    input  logic [NUM_PHASES-1:0]         req,
    output logic [$clog2(NUM_PHASES)-1:0] nxt,
    output logic                          found
);
    localparam int PH_W = $clog2(NUM_PHASES);

    // Walk from the farthest offset down so the nearest qualifying phase wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            if (req[(int'(cur) + k) % NUM_PHASES]) begin
                nxt   = PH_W'((int'(cur) + k) % NUM_PHASES);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-phase traffic light sequencer with table-driven dwell/patterns, demand skipping,
// start-up all-red clearance and amber flash mode.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ALL_RED | every head red, counting down the clearance before phase 0
//   RUN     | a phase is active, remain counts its dwell down in ticks
//   FLASH   | every head toggles amber/off on each tick
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES    = 6,
    parameter int NUM_LIGHTS    = 4,
    parameter int DUR_W         = 8,
    parameter int ALL_RED_TICKS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic [NUM_PHASES*DUR_W-1:0]      dur_tbl,
    input  logic [NUM_PHASES*NUM_LIGHTS*3-1:0] pat_tbl,
    input  logic [NUM_PHASES-1:0]            skip_mask,
    input  logic [NUM_PHASES-1:0]            demand,
    input  logic                             flash_en,
    output logic [NUM_LIGHTS*3-1:0]          lights,
    output logic [$clog2(NUM_PHASES)-1:0]    phase,
    output logic                             phase_start,
    output logic                             flashing
);
    localparam int PH_W   = $clog2(NUM_PHASES);
    localparam int AR_W   = $clog2(ALL_RED_TICKS + 1);
    localparam int REM_W  = (DUR_W > AR_W) ? DUR_W : AR_W;
    localparam int LT_W   = NUM_LIGHTS * 3;

    localparam logic [LT_W-1:0]       LIGHTS_RED   = {NUM_LIGHTS{LT_RED}};
    localparam logic [LT_W-1:0]       LIGHTS_AMBER = {NUM_LIGHTS{LT_AMBER}};
    localparam logic [NUM_PHASES-1:0] PHASE0_BIT   = NUM_PHASES'(1);

    tls_state_t             state_q, state_d;
    logic [REM_W-1:0]       remain_q, remain_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [LT_W-1:0]        lights_q, lights_d;
    logic                   phase_start_q, phase_start_d;
    logic                   flashing_q, flashing_d;
    logic [NUM_PHASES-1:0]  dem_lat_q, dem_lat_d;

    logic [NUM_PHASES-1:0]  req;
    logic [PH_W-1:0]        nxt_phase;
    logic                   nxt_found;
    logic                   enter;
    logic [PH_W-1:0]        enter_idx;
    logic [DUR_W-1:0]       dur_sel;
    logic [LT_W-1:0]        pat_sel;

    // Phase 0 always qualifies so the search can never starve the cycle.
    assign req = ~skip_mask | dem_lat_q | PHASE0_BIT;

    traffic_next_phase #(.NUM_PHASES(NUM_PHASES)) u_next (
        .cur   (phase_q),
        .req   (req),
        .nxt   (nxt_phase),
        .found (nxt_found)
    );

    // Decide whether this edge enters a phase, and which one.
    always_comb begin
        enter     = 1'b0;
        enter_idx = '0;
        if (!flash_en && tick && remain_q == REM_W'(1)) begin
            case (state_q)
                ALL_RED: enter = 1'b1;
                RUN: begin
                    enter     = 1'b1;
                    enter_idx = nxt_found ? nxt_phase : phase_q;
                end
                default: enter = 1'b0;
            endcase
        end
    end

    assign dur_sel = dur_tbl[int'(enter_idx) * DUR_W +: DUR_W];
    assign pat_sel = pat_tbl[int'(enter_idx) * LT_W +: LT_W];

    // Next-state, timer and output computation.
    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        phase_d       = phase_q;
        lights_d      = lights_q;
        phase_start_d = 1'b0;
        flashing_d    = flashing_q;
        dem_lat_d     = dem_lat_q | demand;
        if (state_q == RUN) begin
            dem_lat_d[phase_q] = dem_lat_q[phase_q];
        end

        if (flash_en) begin
            state_d    = FLASH;
            phase_d    = '0;
            flashing_d = 1'b1;
            if (state_q != FLASH) begin
                lights_d = LIGHTS_AMBER;
            end else if (tick) begin
                lights_d = (lights_q == LIGHTS_AMBER) ? '0 : LIGHTS_AMBER;
            end
        end else if (state_q == FLASH) begin
            state_d    = ALL_RED;
            remain_d   = REM_W'(ALL_RED_TICKS);
            phase_d    = '0;
            lights_d   = LIGHTS_RED;
            flashing_d = 1'b0;
        end else if (enter) begin
            state_d              = RUN;
            phase_d              = enter_idx;
            remain_d             = (dur_sel == '0) ? REM_W'(1) : REM_W'(dur_sel);
            lights_d             = pat_sel;
            phase_start_d        = 1'b1;
            dem_lat_d[enter_idx] = 1'b0;
        end else if (tick && remain_q != '0) begin
            remain_d = remain_q - REM_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ALL_RED;
            remain_q      <= REM_W'(ALL_RED_TICKS);
            phase_q       <= '0;
            lights_q      <= LIGHTS_RED;
            phase_start_q <= 1'b0;
            flashing_q    <= 1'b0;
            dem_lat_q     <= '0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            phase_q       <= phase_d;
            lights_q      <= lights_d;
            phase_start_q <= phase_start_d;
            flashing_q    <= flashing_d;
            dem_lat_q     <= dem_lat_d;
        end
    end

    assign lights      = lights_q;
    assign phase       = phase_q;
    assign phase_start = phase_start_q;
    assign flashing    = flashing_q;

endmodule
